ifu_fetch_unit: RTL and testbench

- Instruction fetch unit: the upstream (transmitter) end of the IFU->IDU valid/ready handshake.
- Sequential PC generation; one outstanding request on a simple memory request/response bus.
- Presents inst/pc/sequence number to IDU; accepts control-hazard redirects from IDU and flushes the wrong path.

---
 rtl/ifu_fetch_unit.sv | 138 +++++++++++++
 tb/tb_ifu_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, one outstanding memory request,
// valid/ready delivery to IDU with control-hazard redirect and wrong-path flush.
module ifu_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        ifu_valid,
  input  logic        ifu_ready,
  output logic [31:0] inst,
  output logic [31:0] ifu_to_idu_pc,
  output logic [63:0] num,
  input  logic        control_hazard,
  input  logic [31:0] branch_target_pc,
  output logic        fetch_err,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  // state | meaning
  // REQ   | presenting a fetch request at pc
  // WAIT  | request accepted, waiting for the single response
  // HOLD  | instruction presented to IDU until handshake or redirect
  // HALT  | bus error seen; only reset leaves
  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;
  logic [63:0] num_q, num_d;
  logic        drop_q, drop_d;
  logic        err_q, err_d;
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] flcnt_q, flcnt_d;
  logic        redirect;

  assign redirect      = control_hazard && (state_q != ST_HALT);
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = pc_q;
  assign ifu_valid     = (state_q == ST_HOLD) && !control_hazard;
  assign inst          = inst_q;
  assign ifu_to_idu_pc = ipc_q;
  assign num           = num_q;
  assign fetch_err     = err_q;
  assign fetch_count   = fcnt_q;
  assign flush_count   = flcnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    num_d   = num_q;
    drop_d  = drop_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    flcnt_d = flcnt_q;
    case (state_q)
      ST_REQ: begin
        // A redirect coinciding with accept still sends the old address; its response is dropped.
        if (mem_req_ready) begin
          state_d = ST_WAIT;
          drop_d  = redirect;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else if (mem_rsp_err) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            inst_d  = mem_rsp_data;
            ipc_d   = pc_q;
            num_d   = num_q + 64'd1;
            state_d = ST_HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (ifu_ready) begin
          pc_d    = pc_q + PC_STEP;
          fcnt_d  = fcnt_q + 32'd1;
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    if (redirect) begin
      pc_d    = branch_target_pc;
      flcnt_d = flcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      ipc_q   <= 32'd0;
      num_q   <= 64'd0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= 32'd0;
      flcnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      num_q   <= num_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      flcnt_q <= flcnt_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Bench for ifu_fetch_unit: transaction-level model of fetch/deliver/redirect,
// directed scenarios plus randomized traffic with a latency-randomizing memory.
module tb_ifu_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic        ifu_valid, ifu_ready;
  logic [31:0] inst, ifu_to_idu_pc;
  logic [63:0] num;
  logic        control_hazard;
  logic [31:0] branch_target_pc;
  logic        fetch_err;
  logic [31:0] fetch_count, flush_count;

  always #5 clock = ~clock;

  ifu_fetch_unit dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .inst(inst), .ifu_to_idu_pc(ifu_to_idu_pc),
    .num(num), .control_hazard(control_hazard), .branch_target_pc(branch_target_pc),
    .fetch_err(fetch_err), .fetch_count(fetch_count), .flush_count(flush_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural fetch pc, the one in-flight request and the held instruction.
  bit          m_halted, m_holding, m_out, m_killed, m_err;
  int          m_lat;
  logic [31:0] m_pc, m_out_addr, m_inst, m_ipc, m_fcount, m_flcount;
  logic [63:0] m_num;

  int          lat_fix = 1;
  bit          force_en = 0;
  logic [31:0] force_data = 32'hDEAD_BEEF;
  bit          err_next = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic step(input bit hz, input logic [31:0] tgt, input bit mrdy, input bit irdy, input bit spur);
    bit rsp_v, rsp_e, exp_rv, exp_iv, accept, hs;
    logic [258:0] act, exp;
    rsp_v = m_out && (m_lat == 0);
    rsp_e = rsp_v && err_next;
    mem_rsp_valid    = rsp_v || (!m_out && spur);
    mem_rsp_data     = rsp_v ? (force_en ? force_data : mem_word(m_out_addr)) : $urandom;
    mem_rsp_err      = rsp_v ? rsp_e : 1'($urandom);
    mem_req_ready    = mrdy;
    ifu_ready        = irdy;
    control_hazard   = hz;
    branch_target_pc = tgt;
    @(negedge clock);
    exp_rv = !m_halted && !m_out && !m_holding;
    exp_iv = m_holding && !hz;
    act = {mem_req_valid, ifu_valid, fetch_err, mem_req_addr, inst, ifu_to_idu_pc, num, fetch_count, flush_count};
    exp = {exp_rv, exp_iv, m_err, m_pc, m_inst, m_ipc, m_num, m_fcount, m_flcount};
    n_checks++;
    if (act !== exp)
      $display("FAIL cycle_state t=%0t got=%h want=%h (reqv,ifuv,err,addr,inst,pc,num,fcnt,flcnt)", $time, act, exp);
    else
      n_pass++;
    accept = exp_rv && mrdy;
    hs     = exp_iv && irdy;
    if (rsp_v) begin
      m_out = 0;
      if (!(m_killed || hz)) begin
        if (rsp_e) begin
          m_halted = 1;
          m_err    = 1;
        end else begin
          m_holding = 1;
          m_num     = m_num + 64'd1;
          m_inst    = force_en ? force_data : mem_word(m_out_addr);
          m_ipc     = m_out_addr;
        end
      end
    end else if (m_out) begin
      m_lat--;
      m_killed = m_killed || hz;
    end
    if (accept) begin
      m_out      = 1;
      m_out_addr = m_pc;
      m_killed   = hz;
      m_lat      = (lat_fix > 0) ? lat_fix - 1 : $urandom_range(3, 0);
    end
    if (hs) begin
      m_fcount  = m_fcount + 32'd1;
      m_pc      = m_pc + 32'd4;
      m_holding = 0;
    end
    if (hz && !m_halted) begin
      m_pc      = tgt;
      m_flcount = m_flcount + 32'd1;
      m_holding = 0;
    end
    @(posedge clock);
    #1;
  endtask

  // Caller has raised reset; clear the model and release reset aligned to the cycle grid.
  task automatic finish_reset();
    m_halted = 0; m_holding = 0; m_out = 0; m_killed = 0; m_err = 0; m_lat = 0;
    m_pc = RESET_PC; m_out_addr = 0; m_inst = 0; m_ipc = 0; m_num = 0;
    m_fcount = 0; m_flcount = 0;
    control_hazard = 0; mem_rsp_valid = 0; mem_rsp_err = 0; mem_req_ready = 0;
    ifu_ready = 0; mem_rsp_data = 0; branch_target_pc = 0;
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  task automatic restart();
    #2 reset = 1;
    finish_reset();
  endtask

  task automatic test_reset();
    reset = 1;
    #1;
    n_checks++;
    if ({ifu_valid, fetch_err, mem_req_addr, inst, ifu_to_idu_pc, num, fetch_count, flush_count} !==
        {1'b0, 1'b0, RESET_PC, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0})
      $display("FAIL reset_values addr=%h inst=%h pc=%h num=%0d ifuv=%b err=%b", mem_req_addr, inst, ifu_to_idu_pc, num, ifu_valid, fetch_err);
    else n_pass++;
    finish_reset();
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC)
      $display("FAIL reset_request valid=%b addr=%h want 1 %h", mem_req_valid, mem_req_addr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_sequential();
    restart();
    lat_fix = 1;
    for (int k = 0; k < 40 && m_fcount != 3; k++) step(0, 0, 1, 1, 0);
    n_checks++;
    if (fetch_count !== 32'd3 || num !== 64'd3 || ifu_to_idu_pc !== 32'h3000_0008 || mem_req_addr !== 32'h3000_000C)
      $display("FAIL sequential fcnt=%0d num=%0d pc=%h addr=%h want 3 3 30000008 3000000c", fetch_count, num, ifu_to_idu_pc, mem_req_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [31:0] held_pc, fc;
    logic [63:0] held_num;
    restart();
    lat_fix = 2;
    for (int k = 0; k < 20 && !m_holding; k++) step(0, 0, 1, 0, 0);
    held_pc = m_ipc; held_num = m_num; fc = m_fcount;
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0, 0);
    n_checks++;
    if (ifu_valid !== 1'b1 || mem_req_valid !== 1'b0 || num !== held_num || ifu_to_idu_pc !== held_pc)
      $display("FAIL backpressure_hold ifuv=%b reqv=%b num=%0d pc=%h want 1 0 %0d %h", ifu_valid, mem_req_valid, num, ifu_to_idu_pc, held_num, held_pc);
    else n_pass++;
    step(0, 0, 0, 1, 0);
    n_checks++;
    if (fetch_count !== fc + 32'd1 || mem_req_addr !== held_pc + 32'd4)
      $display("FAIL backpressure_release fcnt=%0d addr=%h want %0d %h", fetch_count, mem_req_addr, fc + 1, held_pc + 4);
    else n_pass++;
  endtask

  task automatic test_redirect_hold();
    restart();
    lat_fix = 1;
    for (int k = 0; k < 40 && m_fcount != 2; k++) step(0, 0, 1, 1, 0);
    for (int k = 0; k < 10 && !m_holding; k++) step(0, 0, 1, 0, 0);
    step(1, 32'h3000_0100, 1, 1, 0);
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0100 || flush_count !== 32'd1)
      $display("FAIL redirect_hold_req valid=%b addr=%h flush=%0d want 1 30000100 1", mem_req_valid, mem_req_addr, flush_count);
    else n_pass++;
    for (int k = 0; k < 20 && m_fcount != 3; k++) step(0, 0, 1, 1, 0);
    n_checks++;
    if (ifu_to_idu_pc !== 32'h3000_0100 || num !== 64'd4 || inst !== mem_word(32'h3000_0100))
      $display("FAIL redirect_hold_deliver pc=%h num=%0d inst=%h want 30000100 4 %h", ifu_to_idu_pc, num, inst, mem_word(32'h3000_0100));
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    restart();
    lat_fix = 4;
    for (int k = 0; k < 5 && !m_out; k++) step(0, 0, 1, 1, 0);
    force_en = 1;
    step(1, 32'h3000_0200, 1, 1, 0);
    for (int k = 0; k < 10 && m_out; k++) step(0, 0, 1, 1, 0);
    force_en = 0;
    n_checks++;
    if (inst === 32'hDEAD_BEEF || num !== 64'd0 || mem_req_addr !== 32'h3000_0200)
      $display("FAIL redirect_wait_drop inst=%h num=%0d addr=%h want !deadbeef 0 30000200", inst, num, mem_req_addr);
    else n_pass++;
    for (int k = 0; k < 20 && m_fcount != 1; k++) step(0, 0, 1, 1, 0);
    n_checks++;
    if (num !== 64'd1 || ifu_to_idu_pc !== 32'h3000_0200)
      $display("FAIL redirect_wait_next num=%0d pc=%h want 1 30000200", num, ifu_to_idu_pc);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    restart();
    lat_fix = 2;
    step(1, 32'h3000_0300, 1, 1, 0);
    for (int k = 0; k < 20 && m_fcount != 1; k++) step(0, 0, 1, 1, 0);
    n_checks++;
    if (ifu_to_idu_pc !== 32'h3000_0300 || num !== 64'd1 || flush_count !== 32'd1)
      $display("FAIL accept_redirect pc=%h num=%0d flush=%0d want 30000300 1 1", ifu_to_idu_pc, num, flush_count);
    else n_pass++;
    for (int k = 0; k < 5 && !m_out; k++) step(0, 0, 1, 1, 0);
    for (int k = 0; k < 5 && m_lat != 0; k++) step(0, 0, 1, 1, 0);
    step(1, 32'h3000_0400, 0, 1, 0);
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h3000_0400 || num !== 64'd1 || flush_count !== 32'd2)
      $display("FAIL rsp_redirect valid=%b addr=%h num=%0d flush=%0d want 1 30000400 1 2", mem_req_valid, mem_req_addr, num, flush_count);
    else n_pass++;
  endtask

  task automatic test_error();
    restart();
    lat_fix = 2;
    err_next = 1;
    for (int k = 0; k < 10 && !m_halted; k++) step(0, 0, 1, 1, 0);
    err_next = 0;
    for (int k = 0; k < 4; k++) step(1, $urandom, 1, 1, 1);
    n_checks++;
    if (fetch_err !== 1'b1 || mem_req_valid !== 1'b0 || ifu_valid !== 1'b0 || flush_count !== 32'd0)
      $display("FAIL error_halt err=%b reqv=%b ifuv=%b flush=%0d want 1 0 0 0", fetch_err, mem_req_valid, ifu_valid, flush_count);
    else n_pass++;
    restart();
    lat_fix = 3;
    for (int k = 0; k < 40 && m_fcount != 1; k++) step(0, 0, 1, 1, 0);
    for (int k = 0; k < 5 && !m_out; k++) step(0, 0, 1, 1, 0);
    #2 reset = 1;
    #1;
    n_checks++;
    if (mem_req_addr !== RESET_PC || fetch_count !== 32'd0 || num !== 64'd0 || fetch_err !== 1'b0)
      $display("FAIL reset_mid_wait addr=%h fcnt=%0d num=%0d err=%b want %h 0 0 0", mem_req_addr, fetch_count, num, fetch_err, RESET_PC);
    else n_pass++;
    finish_reset();
    step(0, 0, 0, 1, 1);
    for (int k = 0; k < 20 && m_fcount != 1; k++) step(0, 0, 1, 1, 0);
    n_checks++;
    if (ifu_to_idu_pc !== RESET_PC || num !== 64'd1)
      $display("FAIL after_reset_fetch pc=%h num=%0d want %h 1", ifu_to_idu_pc, num, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_wrap();
    restart();
    lat_fix = 1;
    step(1, 32'hFFFF_FFFC, 0, 1, 0);
    for (int k = 0; k < 20 && m_fcount != 1; k++) step(0, 0, 1, 1, 0);
    n_checks++;
    if (ifu_to_idu_pc !== 32'hFFFF_FFFC || mem_req_addr !== 32'h0000_0000)
      $display("FAIL pc_wrap pc=%h addr=%h want fffffffc 00000000", ifu_to_idu_pc, mem_req_addr);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    restart();
    lat_fix = 0;
    for (int k = 0; k < 4000; k++) begin
      if (m_halted && $urandom_range(7, 0) == 0) restart();
      err_next = ($urandom_range(149, 0) == 0);
      tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 + {$urandom_range(1, 0), 2'b00} : {$urandom, 2'b00};
      step($urandom_range(7, 0) == 0, tgt, $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0, 1'($urandom));
    end
    err_next = 0;
    n_checks++;
    if (fetch_count !== m_fcount || flush_count !== m_flcount)
      $display("FAIL random_counts fcnt=%0d flush=%0d want %0d %0d", fetch_count, flush_count, m_fcount, m_flcount);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_hold();
    test_redirect_wait();
    test_same_cycle();
    test_error();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
